memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 SHALL take TIMEOUT, default 16, the number of WAIT cycles without mem_ack before a transfer is aborted.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 res  in  32  ALU result from EX; byte address for loads/stores.
REQ-006 write_data_ex  in  32  store data (forwarded rt).
REQ-007 write_register_ex  in  5  destination register.
REQ-008 m_MEM  in  4  [3]=mem_read, [2]=mem_write, [1:0]=size (00 word, 01 half signed, 10 byte signed, 11 byte unsigned).
REQ-009 wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg.
REQ-010 mem_ack  in  1  data-memory completion strobe.
REQ-011 mem_rdata  in  32  read word, valid with mem_ack.
REQ-012 mem_req, mem_we  out  1 each  request, write enable.
REQ-013 mem_addr  out  32  word address, {res[31:2],2'b00}.
REQ-014 mem_wdata  out  32  lane-replicated store data; mem_be  out  4  byte enables.
REQ-015 stall_mem  out  1  freezes PC/IF/ID/EX while high.
REQ-016 addr_err, bus_err  out  1 each  single-cycle error pulses.
REQ-017 read_data_wb, alu_res_wb  out  32 each; rd_WB  out  5; wb_WB  out  2; all registered toward WB.

Function
REQ-018 An access SHALL occur when m_MEM[3] or m_MEM[2] is set; mem_read takes priority when both are set.
REQ-019 Misaligned accesses (word with res[1:0]!=0, half with res[0]!=0) SHALL issue no request, pulse addr_err for one cycle, and send a bubble (wb_WB=0) to WB.
REQ-020 The FSM SHALL have two states: IDLE and WAIT.
REQ-021 In IDLE, on a legal access, mem_req SHALL be asserted combinationally in that cycle; mem_ack in the same cycle completes with zero wait.
REQ-022 In IDLE, an access without mem_ack SHALL move the FSM to WAIT.
REQ-023 In WAIT, mem_req, mem_addr, mem_we, mem_wdata and mem_be SHALL stay stable until mem_ack or timeout.
REQ-024 stall_mem SHALL equal (legal access pending) AND NOT mem_ack, combinationally.
REQ-025 A wait counter SHALL clear on entering WAIT and increment once per WAIT cycle.
REQ-026 When the wait counter reaches TIMEOUT without mem_ack, the block SHALL drop mem_req, pulse bus_err, send a bubble to WB, release stall_mem and return to IDLE.
REQ-027 mem_ack received while mem_req is low SHALL be ignored.
REQ-028 Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by res[1:0].
REQ-029 Store byte: mem_be = 1<<res[1:0], mem_wdata = the byte replicated x4.
REQ-030 Store half: mem_be = 0011 or 1100, mem_wdata = the half replicated x2.
REQ-031 Store word: mem_be = 1111.
REQ-032 Loads SHALL extract the addressed lane from mem_rdata and sign- or zero-extend it per size.
REQ-033 On each cycle with stall_mem=0, the WB register SHALL load read_data_wb, alu_res_wb<=res, rd_WB<=write_register_ex and wb_WB<=wb_MEM (or 0 on a bubble).
REQ-034 While stall_mem=1, the WB register SHALL load wb_WB=0, so no register write happens.
REQ-035 A completed store SHALL forward wb_MEM unchanged; its reg_write is 0 by decode.

Reset
REQ-036 On rst at a clock edge, the FSM SHALL go to IDLE, the wait counter to 0, and every registered output to 0.
REQ-037 A reset during WAIT SHALL abandon the transfer, with mem_req low from the next cycle.

Structure
REQ-038 The m_MEM field positions, the size encodings, the state enum and the TIMEOUT default SHALL live in a shared package mips_pkg.
REQ-039 Load alignment and extension SHALL be one sub-module, load_extract (mem_rdata, addr[1:0], size -> 32-bit data).

Verification
REQ-040 Zero-wait word load: res=0x100, m=1000, ack same cycle, rdata=0xDEADBEEF -> stall_mem never set; next cycle read_data_wb=0xDEADBEEF, wb_WB=wb_MEM.
REQ-041 Signed byte load at res=0x103, rdata=0x80xxxxxx -> read_data_wb=0xFFFFFF80; the same case with size 11 -> 0x00000080.
REQ-042 Byte store of 0x000000A5 to res=0x202, ack after 3 cycles -> mem_be=0100, mem_wdata=0xA5A5A5A5 held stable, stall_mem high for exactly 3 cycles, wb_WB=0 during those cycles.
REQ-043 Word load at res=0x102 -> addr_err pulses once, mem_req stays 0, wb_WB=0.
REQ-044 No ack for 16 WAIT cycles -> bus_err pulse, mem_req drops, stall_mem releases, FSM in IDLE; a later ack is ignored.
REQ-045 rst asserted in the 2nd WAIT cycle -> next cycle mem_req=0, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: control field positions, access sizes, FSM states.
package mips_pkg;

  localparam int unsigned M_READ          = 3;
  localparam int unsigned M_WRITE         = 2;
  localparam int unsigned M_SIZE_LSB      = 0;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_BYTE  = 2'b10,
    SZ_BYTEU = 2'b11
  } size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Natural alignment: words on 4-byte, halves on 2-byte, bytes anywhere.
  function automatic logic is_aligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_WORD: return off == 2'b00;
      SZ_HALF: return !off[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed little-endian lane of a read word and extends it to 32 bits.
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  size_e       size,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane pick followed by sign or zero extension.
  always_comb begin
    byte_v = mem_rdata[{addr, 3'b000} +: 8];
    half_v = mem_rdata[{addr[1], 4'b0000} +: 16];
    case (size)
      SZ_WORD:  data = mem_rdata;
      SZ_HALF:  data = {{16{half_v[15]}}, half_v};
      SZ_BYTE:  data = {{24{byte_v[7]}}, byte_v};
      default:  data = {24'h000000, byte_v};
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: issues data-memory requests, stalls the pipeline while waiting,
// aborts on timeout and registers results toward WB.
module memory_access
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register_ex,
  input  logic [3:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall_mem,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] read_data_wb,
  output logic [31:0] alu_res_wb,
  output logic [4:0]  rd_WB,
  output logic [1:0]  wb_WB
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          timeout;
  logic          mem_read, mem_write, access, aligned, legal, misaligned_idle;
  size_e         mem_size;
  logic [31:0]   load_data;

  assign mem_read        = m_MEM[M_READ];
  assign mem_write       = m_MEM[M_WRITE];
  assign mem_size        = size_e'(m_MEM[M_SIZE_LSB +: 2]);
  assign access          = mem_read | mem_write;
  assign aligned         = is_aligned(mem_size, res[1:0]);
  assign legal           = access & aligned;
  assign misaligned_idle = (state == S_IDLE) & access & !aligned;

  load_extract u_load_extract (
    .mem_rdata (mem_rdata),
    .addr      (res[1:0]),
    .size      (mem_size),
    .data      (load_data)
  );

  // Next state, wait counter and request/stall handshake.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mem_req   = 1'b0;
    stall_mem = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (legal) begin
          mem_req   = 1'b1;
          stall_mem = !mem_ack;
          if (!mem_ack) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CW'(TIMEOUT)) begin
          // Abort cycle: request dropped, stall released, late acks ignored.
          timeout = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          mem_req   = 1'b1;
          stall_mem = !mem_ack;
          if (mem_ack) state_n = S_IDLE;
          else         cnt_n   = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request address, write enable, byte enables and lane-replicated store data.
  always_comb begin
    mem_addr = {res[31:2], 2'b00};
    mem_we   = mem_req & mem_write & !mem_read;
    case (mem_size)
      SZ_WORD: begin
        mem_be    = 4'b1111;
        mem_wdata = write_data_ex;
      end
      SZ_HALF: begin
        mem_be    = res[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{write_data_ex[15:0]}};
      end
      default: begin
        mem_be    = 4'b0001 << res[1:0];
        mem_wdata = {4{write_data_ex[7:0]}};
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // WB pipeline register and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_wb <= '0;
      alu_res_wb   <= '0;
      rd_WB        <= '0;
      wb_WB        <= '0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      read_data_wb <= load_data;
      alu_res_wb   <= res;
      rd_WB        <= write_register_ex;
      addr_err     <= misaligned_idle;
      bus_err      <= timeout;
      if (stall_mem || misaligned_idle || timeout) wb_WB <= '0;
      else                                          wb_WB <= wb_MEM;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res, write_data_ex, mem_rdata;
  logic [4:0]  write_register_ex;
  logic [3:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        mem_ack;
  logic        mem_req, mem_we, stall_mem, addr_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, read_data_wb, alu_res_wb;
  logic [3:0]  mem_be;
  logic [4:0]  rd_WB;
  logic [1:0]  wb_WB;

  int errors = 0;
  int checks = 0;

  memory_access dut (
    .clk(clk), .rst(rst), .res(res), .write_data_ex(write_data_ex),
    .write_register_ex(write_register_ex), .m_MEM(m_MEM), .wb_MEM(wb_MEM),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .stall_mem(stall_mem), .addr_err(addr_err), .bus_err(bus_err),
    .read_data_wb(read_data_wb), .alu_res_wb(alu_res_wb), .rd_WB(rd_WB), .wb_WB(wb_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: addressed lane of rdata, extended according to size code.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int sz);
    longint unsigned v;
    case (sz)
      0: return rd;
      1: begin
        v = (longint'(rd) >> (8 * (off / 2 * 2))) % 65536;
        return (v >= 32768) ? 32'(v + 64'hFFFF0000) : 32'(v);
      end
      2: begin
        v = (longint'(rd) >> (8 * off)) % 256;
        return (v >= 128) ? 32'(v + 64'hFFFFFF00) : 32'(v);
      end
      default: return 32'((longint'(rd) >> (8 * off)) % 256);
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int off, input int sz);
    case (sz)
      0: return 4'd15;
      1: return 4'(3 << off);
      default: return 4'(1 << off);
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int sz);
    case (sz)
      0: return wd;
      1: return 32'((wd % 65536) * 65537);
      default: return 32'((wd % 256) * 32'h01010101);
    endcase
  endfunction

  function automatic bit ref_aligned(input int off, input int sz);
    if (sz == 0) return off == 0;
    if (sz == 1) return off % 2 == 0;
    return 1'b1;
  endfunction

  initial begin
    logic [31:0] r_res, r_wd, r_rd;
    int          sz, off, dly;
    bit          rd, wr;
    logic [1:0]  r_wb;
    logic [4:0]  r_reg;

    rst = 1'b1; res = 32'h0; write_data_ex = 32'h0; mem_rdata = 32'h0;
    write_register_ex = 5'd0; m_MEM = 4'b0; wb_MEM = 2'b0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_wb", 32'(wb_WB), 32'h0);
    chk("rst_alu", alu_res_wb, 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    rst = 1'b0;

    // Zero-wait word load.
    res = 32'h100; m_MEM = 4'b1000; wb_MEM = 2'b11; write_register_ex = 5'd5;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("zw_stall", 32'(stall_mem), 32'h0);
    chk("zw_req", 32'(mem_req), 32'h1);
    chk("zw_addr", mem_addr, 32'h100);
    tick();
    chk("zw_rdata", read_data_wb, 32'hDEADBEEF);
    chk("zw_wb", 32'(wb_WB), 32'h3);
    chk("zw_rd", 32'(rd_WB), 32'h5);

    // Signed and unsigned byte loads from lane 3.
    res = 32'h103; m_MEM = 4'b1010; mem_rdata = 32'h80123456; #1;
    tick();
    chk("lb_signed", read_data_wb, 32'hFFFFFF80);
    m_MEM = 4'b1011; #1;
    tick();
    chk("lb_unsigned", read_data_wb, 32'h00000080);

    // Byte store with three wait cycles.
    res = 32'h202; m_MEM = 4'b0110; write_data_ex = 32'h000000A5; wb_MEM = 2'b01;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sb_stall", 32'(stall_mem), 32'h1);
      chk("sb_be", 32'(mem_be), 32'h4);
      chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("sb_we", 32'(mem_we), 32'h1);
      tick();
      chk("sb_wb_bubble", 32'(wb_WB), 32'h0);
    end
    mem_ack = 1'b1; #1;
    chk("sb_ack_stall", 32'(stall_mem), 32'h0);
    tick();
    chk("sb_wb", 32'(wb_WB), 32'h1);

    // Misaligned word load.
    res = 32'h102; m_MEM = 4'b1000; wb_MEM = 2'b11; mem_ack = 1'b0; #1;
    chk("mis_req", 32'(mem_req), 32'h0);
    chk("mis_stall", 32'(stall_mem), 32'h0);
    tick();
    chk("mis_addr_err", 32'(addr_err), 32'h1);
    chk("mis_wb", 32'(wb_WB), 32'h0);
    m_MEM = 4'b0; wb_MEM = 2'b00;
    tick();
    chk("mis_pulse_end", 32'(addr_err), 32'h0);

    // Timeout: one IDLE cycle plus 16 WAIT cycles with no ack, then abort.
    res = 32'h300; m_MEM = 4'b1000; wb_MEM = 2'b11;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("to_req", 32'(mem_req), 32'h1);
      chk("to_stall", 32'(stall_mem), 32'h1);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("to_drop_req", 32'(mem_req), 32'h0);
    chk("to_release", 32'(stall_mem), 32'h0);
    tick();
    chk("to_bus_err", 32'(bus_err), 32'h1);
    chk("to_wb", 32'(wb_WB), 32'h0);
    m_MEM = 4'b0; wb_MEM = 2'b10; #1;
    chk("late_ack_req", 32'(mem_req), 32'h0);
    tick();
    chk("to_pulse_end", 32'(bus_err), 32'h0);
    chk("late_ack_wb", 32'(wb_WB), 32'h2);
    mem_ack = 1'b0;
    res = 32'h301; m_MEM = 4'b1000; #1;
    chk("to_idle", 32'(mem_req), 32'h0);
    tick();
    m_MEM = 4'b0;

    // Reset in the 2nd WAIT cycle.
    res = 32'h400; m_MEM = 4'b1000; wb_MEM = 2'b11; write_register_ex = 5'd9;
    tick(); tick();
    rst = 1'b1; m_MEM = 4'b0;
    tick();
    rst = 1'b0; #1;
    chk("rw_req", 32'(mem_req), 32'h0);
    chk("rw_stall", 32'(stall_mem), 32'h0);
    chk("rw_alu", alu_res_wb, 32'h0);
    chk("rw_rd", 32'(rd_WB), 32'h0);
    chk("rw_wb", 32'(wb_WB), 32'h0);
    res = 32'h403; m_MEM = 4'b1000; #1;
    chk("rw_idle", 32'(mem_req), 32'h0);
    tick();
    m_MEM = 4'b0; tick();

    // Randomized transactions against the reference model.
    for (int t = 0; t < 200; t++) begin
      r_res = $urandom; r_wd = $urandom; r_rd = $urandom;
      sz = int'($urandom_range(0, 3)); off = int'(r_res % 4);
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      r_wb = 2'($urandom); r_reg = 5'($urandom);
      dly = int'($urandom_range(0, 3));
      res = r_res; write_data_ex = r_wd; mem_rdata = r_rd;
      m_MEM = {rd, wr, 2'(sz)}; wb_MEM = r_wb; write_register_ex = r_reg;
      mem_ack = 1'b0;
      if ((rd || wr) && ref_aligned(off, sz)) begin
        for (int i = 0; i < dly; i++) begin
          #1;
          chk("r_stall", 32'(stall_mem), 32'h1);
          chk("r_addr", mem_addr, r_res - 32'(off));
          if (!rd) begin
            chk("r_be", 32'(mem_be), 32'(ref_be(off, sz)));
            chk("r_wdata", mem_wdata, ref_wdata(r_wd, sz));
          end
          chk("r_we", 32'(mem_we), 32'(!rd));
          tick();
          chk("r_wb_bubble", 32'(wb_WB), 32'h0);
        end
        mem_ack = 1'b1; #1;
        chk("r_req", 32'(mem_req), 32'h1);
        chk("r_ack_stall", 32'(stall_mem), 32'h0);
        tick();
        chk("r_wb", 32'(wb_WB), 32'(r_wb));
        chk("r_alu", alu_res_wb, r_res);
        chk("r_rdreg", 32'(rd_WB), 32'(r_reg));
        if (rd) chk("r_load", read_data_wb, ref_load(r_rd, off, sz));
      end else if (rd || wr) begin
        #1;
        chk("r_mis_req", 32'(mem_req), 32'h0);
        tick();
        chk("r_mis_err", 32'(addr_err), 32'h1);
        chk("r_mis_wb", 32'(wb_WB), 32'h0);
      end else begin
        #1;
        chk("r_none_req", 32'(mem_req), 32'h0);
        tick();
        chk("r_none_wb", 32'(wb_WB), 32'(r_wb));
        chk("r_none_err", 32'(addr_err), 32'h0);
      end
      mem_ack = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
